mem_refill: RTL and testbench
=============================

MEM_REFILL -- requirements
Module: mem_refill

Interface
REQ-001 SHALL have parameter PA_WIDTH, default 20, physical address width.
REQ-002 SHALL have parameter LINE_BYTES, default 16, bytes per cache line.
REQ-003 SHALL have parameter ID_WIDTH, default 2, memory transaction ID width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, response watchdog limit.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, on ports clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 i_req_valid  input  1  cache miss or writeback request.
REQ-009 i_req_addr  input  PA_WIDTH  line address.
REQ-010 i_req_write  input  1  1 = writeback, 0 = refill.
REQ-011 i_req_data  input  LINE_BYTES*8  writeback line.
REQ-012 o_req_ready  output  1  block is IDLE and can accept a request.
REQ-013 o_mem_enable, o_mem_write  output  1 each  request toward the arbiter.
REQ-014 o_mem_addr  output  PA_WIDTH; o_mem_data  output  LINE_BYTES*8.
REQ-015 i_mem_in_use  input  1  other port owns the arbiter this cycle.
REQ-016 i_mem_full  input  1  memory cannot accept a request.
REQ-017 i_mem_id_request  input  ID_WIDTH  ID the arbiter assigns this cycle.
REQ-018 i_mem_enable  input  1  response valid; i_mem_id_response  input  ID_WIDTH; i_mem_data  input  LINE_BYTES*8.
REQ-019 o_mem_ack  output  1  response consumed.
REQ-020 o_rsp_valid, o_rsp_error  output  1 each; o_rsp_data  output  LINE_BYTES*8  result to the cache.

Function
REQ-021 The state machine SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-022 IDLE: o_req_ready=1; when i_req_valid=1, latch addr, write and data, then go to ISSUE.
REQ-023 ISSUE: o_mem_enable=1 with the latched addr, data and write; all three are held stable until the request is granted.
REQ-024 Grant is the cycle in ISSUE with i_mem_in_use=0 and i_mem_full=0; on grant, latch i_mem_id_request as my_id and go to WAIT next cycle.
REQ-025 WAIT: o_mem_enable=0; a response matches when i_mem_enable=1 and i_mem_id_response==my_id.
REQ-026 On a match, o_mem_ack=1 combinationally in that same cycle, i_mem_data is latched, and the state goes to DONE.
REQ-027 A non-matching response SHALL be ignored, with o_mem_ack=0.
REQ-028 DONE: o_rsp_valid=1 for exactly one cycle, with o_rsp_data equal to the latched line (all zeros for a writeback), then go to IDLE.
REQ-029 Minimum latency from request to o_rsp_valid is 3 cycles plus the memory latency; back-to-back requests SHALL be accepted on the cycle after DONE.
REQ-030 i_req_valid outside IDLE SHALL be ignored, with no queuing.
REQ-031 o_mem_ack SHALL be 0 in every state except a matching WAIT cycle.

Reset
REQ-032 While rst=0: state=IDLE, my_id=0, latched data=0, timeout counter=0.
REQ-033 Output values under reset: o_req_ready=1; o_mem_enable, o_mem_write, o_mem_ack, o_rsp_valid and o_rsp_error all 0; buses all 0.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction; a late response after reset release SHALL NOT be acked.

Configuration
REQ-035 Macro MEM_REFILL_TIMEOUT_EN.
REQ-036 When defined: a counter clears on entry to WAIT and increments each WAIT cycle; reaching TIMEOUT_CYCLES-1 without a match goes to DONE with o_rsp_error=1 and o_rsp_data=0.
REQ-037 When not defined: there is no counter, o_rsp_error is tied to 0, and WAIT persists until a match.
REQ-038 A match on the expiry cycle SHALL take priority over the timeout (no error).

Verification
REQ-039 Refill addr 0x00140, memory responds id=1 after 5 cycles -> o_mem_ack pulses once, o_rsp_valid one cycle later with the matching data, o_rsp_error=0.
REQ-040 i_mem_in_use=1 for 3 cycles in ISSUE -> o_mem_enable held with stable addr; grant on the 4th cycle latches i_mem_id_request=2.
REQ-041 WAIT with my_id=2, response id=0 followed by id=2 -> no ack on id=0; ack and DONE on id=2.
REQ-042 Writeback 0xDEAD.. to addr 0x00200 -> o_mem_write=1 in ISSUE; on response, o_rsp_valid=1 with o_rsp_data=0.
REQ-043 With MEM_REFILL_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, no response -> o_rsp_valid=1 and o_rsp_error=1 exactly 8 cycles after WAIT entry.
REQ-044 rst=0 pulsed during WAIT, then the old id responds -> o_mem_ack=0, state IDLE, o_req_ready=1.

Source files
------------

// File: rtl/mem_refill.sv
// mem_refill: cache line refill/writeback engine with ID-matched responses; optional watchdog via MEM_REFILL_TIMEOUT_EN
module mem_refill #(
  parameter int PA_WIDTH       = 20,
  parameter int LINE_BYTES     = 16,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_valid,
  input  logic [PA_WIDTH-1:0]     i_req_addr,
  input  logic                    i_req_write,
  input  logic [LINE_BYTES*8-1:0] i_req_data,
  output logic                    o_req_ready,
  output logic                    o_mem_enable,
  output logic                    o_mem_write,
  output logic [PA_WIDTH-1:0]     o_mem_addr,
  output logic [LINE_BYTES*8-1:0] o_mem_data,
  input  logic                    i_mem_in_use,
  input  logic                    i_mem_full,
  input  logic [ID_WIDTH-1:0]     i_mem_id_request,
  input  logic                    i_mem_enable,
  input  logic [ID_WIDTH-1:0]     i_mem_id_response,
  input  logic [LINE_BYTES*8-1:0] i_mem_data,
  output logic                    o_mem_ack,
  output logic                    o_rsp_valid,
  output logic                    o_rsp_error,
  output logic [LINE_BYTES*8-1:0] o_rsp_data
);
  localparam int LW = LINE_BYTES * 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [PA_WIDTH-1:0] addr_q;
  logic                write_q;
  logic [LW-1:0]       wdata_q, line_q;
  logic [ID_WIDTH-1:0] my_id;
  logic                grant, match, timeout;
  assign grant = state == ISSUE && !i_mem_in_use && !i_mem_full;
  assign match = state == WAIT && i_mem_enable && i_mem_id_response == my_id;
`ifdef MEM_REFILL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          err_q;
  // watchdog counts WAIT cycles from zero; a match on the expiry cycle wins
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (grant) cnt <= '0;
    else if (state == WAIT) cnt <= cnt + 1'b1;
  assign timeout = state == WAIT && !match && cnt == CW'(TIMEOUT_CYCLES - 1);
  // error flag is only ever set on the WAIT->DONE timeout edge, so it lives for the DONE cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) err_q <= 1'b0;
    else err_q <= timeout;
  assign o_rsp_error = state == DONE && err_q;
`else
  assign timeout     = 1'b0;
  assign o_rsp_error = TIMEOUT_CYCLES < 0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = i_req_valid ? ISSUE : IDLE;
      ISSUE:   state_n = grant ? WAIT : ISSUE;
      WAIT:    state_n = (match || timeout) ? DONE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  // capture the request only while idle; anything offered later is dropped
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (state == IDLE && i_req_valid) begin
      addr_q  <= i_req_addr;
      write_q <= i_req_write;
      wdata_q <= i_req_data;
    end
  // grant records our ID and clears the result line, which a timeout leaves at zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      my_id  <= '0;
      line_q <= '0;
    end else if (grant) begin
      my_id  <= i_mem_id_request;
      line_q <= '0;
    end else if (match) line_q <= write_q ? '0 : i_mem_data;
  assign o_req_ready  = state == IDLE;
  assign o_mem_enable = state == ISSUE;
  assign o_mem_write  = state == ISSUE && write_q;
  assign o_mem_addr   = state == ISSUE ? addr_q : '0;
  assign o_mem_data   = state == ISSUE ? wdata_q : '0;
  assign o_mem_ack    = match;
  assign o_rsp_valid  = state == DONE;
  assign o_rsp_data   = state == DONE ? line_q : '0;
endmodule

// File: tb/tb_mem_refill.sv
// tb_mem_refill: directed self-checking bench for mem_refill
module tb_mem_refill;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_req_valid = 1'b0;
  logic [19:0]  i_req_addr = '0;
  logic         i_req_write = 1'b0;
  logic [127:0] i_req_data = '0;
  logic         o_req_ready, o_mem_enable, o_mem_write;
  logic [19:0]  o_mem_addr;
  logic [127:0] o_mem_data;
  logic         i_mem_in_use = 1'b0;
  logic         i_mem_full = 1'b0;
  logic [1:0]   i_mem_id_request = '0;
  logic         i_mem_enable = 1'b0;
  logic [1:0]   i_mem_id_response = '0;
  logic [127:0] i_mem_data = '0;
  logic         o_mem_ack, o_rsp_valid, o_rsp_error;
  logic [127:0] o_rsp_data;
  int checks = 0;
  int errors = 0;
  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2 = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
  localparam logic [127:0] WB = {8{16'hDEAD}};

  mem_refill #(.PA_WIDTH(20), .LINE_BYTES(16), .ID_WIDTH(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_write(i_req_write), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_mem_enable(o_mem_enable), .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_in_use(i_mem_in_use), .i_mem_full(i_mem_full), .i_mem_id_request(i_mem_id_request),
    .i_mem_enable(i_mem_enable), .i_mem_id_response(i_mem_id_response), .i_mem_data(i_mem_data),
    .o_mem_ack(o_mem_ack), .o_rsp_valid(o_rsp_valid), .o_rsp_error(o_rsp_error), .o_rsp_data(o_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_ready", o_req_ready, 1);
    chk("rst_en", o_mem_enable, 0);
    chk("rst_wr", o_mem_write, 0);
    chk("rst_ack", o_mem_ack, 0);
    chk("rst_vld", o_rsp_valid, 0);
    chk("rst_err", o_rsp_error, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_rdata", o_rsp_data, 0);
    tick();
    rst = 1'b1;
    tick();
    // refill 0x00140, response id=1 after 5 cycles
    i_req_valid = 1'b1; i_req_addr = 20'h00140; i_req_write = 1'b0; i_req_data = '0;
    settle();
    chk("t1_ready", o_req_ready, 1);
    tick();
    i_req_valid = 1'b0; i_mem_id_request = 2'd1;
    settle();
    chk("t1_en", o_mem_enable, 1);
    chk("t1_addr", o_mem_addr, 20'h00140);
    chk("t1_wr", o_mem_write, 0);
    chk("t1_ready_busy", o_req_ready, 0);
    tick();
    i_mem_id_request = 2'd0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t1_wait_en", o_mem_enable, 0);
      chk("t1_wait_ack", o_mem_ack, 0);
      chk("t1_wait_vld", o_rsp_valid, 0);
      tick();
    end
    i_mem_enable = 1'b1; i_mem_id_response = 2'd1; i_mem_data = D1;
    settle();
    chk("t1_ack", o_mem_ack, 1);
    chk("t1_vld_early", o_rsp_valid, 0);
    tick();
    i_mem_enable = 1'b0; i_mem_data = '0;
    settle();
    chk("t1_vld", o_rsp_valid, 1);
    chk("t1_data", o_rsp_data, D1);
    chk("t1_err", o_rsp_error, 0);
    chk("t1_ack_done", o_mem_ack, 0);
    chk("t1_ready_done", o_req_ready, 0);
    tick();
    chk("t1_vld_once", o_rsp_valid, 0);
    chk("t1_ready_back", o_req_ready, 1);
    // back-to-back request; arbiter busy 3 cycles, grant with id=2
    i_req_valid = 1'b1; i_req_addr = 20'h00A40;
    tick();
    i_req_addr = 20'h0FFF0; i_mem_in_use = 1'b1; i_mem_id_request = 2'd3;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t2_hold_en", o_mem_enable, 1);
      chk("t2_hold_addr", o_mem_addr, 20'h00A40);
      tick();
    end
    i_req_valid = 1'b0; i_mem_in_use = 1'b0; i_mem_full = 1'b1;
    settle();
    chk("t2_full_en", o_mem_enable, 1);
    tick();
    i_mem_full = 1'b0; i_mem_id_request = 2'd2;
    settle();
    chk("t2_grant_en", o_mem_enable, 1);
    chk("t2_grant_addr", o_mem_addr, 20'h00A40);
    tick();
    i_mem_id_request = 2'd0;
    i_mem_enable = 1'b1; i_mem_id_response = 2'd0; i_mem_data = D1;
    settle();
    chk("t2_en_off", o_mem_enable, 0);
    chk("t2_nomatch_ack", o_mem_ack, 0);
    tick();
    i_mem_id_response = 2'd2; i_mem_data = D2;
    settle();
    chk("t2_nomatch_vld", o_rsp_valid, 0);
    chk("t2_match_ack", o_mem_ack, 1);
    tick();
    i_mem_enable = 1'b0;
    settle();
    chk("t2_vld", o_rsp_valid, 1);
    chk("t2_data", o_rsp_data, D2);
    tick();
    // writeback 0xDEAD.. to 0x00200
    i_req_valid = 1'b1; i_req_addr = 20'h00200; i_req_write = 1'b1; i_req_data = WB;
    tick();
    i_req_valid = 1'b0; i_req_write = 1'b0; i_req_data = '0; i_mem_id_request = 2'd3;
    settle();
    chk("t3_wr", o_mem_write, 1);
    chk("t3_addr", o_mem_addr, 20'h00200);
    chk("t3_data", o_mem_data, WB);
    tick();
    i_mem_enable = 1'b1; i_mem_id_response = 2'd3; i_mem_data = D1;
    settle();
    chk("t3_wr_off", o_mem_write, 0);
    chk("t3_ack", o_mem_ack, 1);
    tick();
    i_mem_enable = 1'b0;
    settle();
    chk("t3_vld", o_rsp_valid, 1);
    chk("t3_rdata_zero", o_rsp_data, 0);
    tick();
    // no response: watchdog fires 8 cycles after WAIT entry, or WAIT persists
    i_req_valid = 1'b1; i_req_addr = 20'h00300;
    tick();
    i_req_valid = 1'b0; i_mem_id_request = 2'd1;
    tick();
`ifdef MEM_REFILL_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("t4_no_vld", o_rsp_valid, 0);
      tick();
    end
    settle();
    chk("t4_to_vld", o_rsp_valid, 1);
    chk("t4_to_err", o_rsp_error, 1);
    chk("t4_to_data", o_rsp_data, 0);
    tick();
    chk("t4_to_ready", o_req_ready, 1);
    chk("t4_to_err_clr", o_rsp_error, 0);
`else
    for (int i = 0; i < 20; i++) begin
      settle();
      chk("t4_persist_vld", o_rsp_valid, 0);
      chk("t4_persist_err", o_rsp_error, 0);
      tick();
    end
    i_mem_enable = 1'b1; i_mem_id_response = 2'd1; i_mem_data = D2;
    settle();
    chk("t4_late_ack", o_mem_ack, 1);
    tick();
    i_mem_enable = 1'b0;
    settle();
    chk("t4_late_data", o_rsp_data, D2);
    chk("t4_late_err", o_rsp_error, 0);
    tick();
`endif
    // reset during WAIT abandons the transaction
    i_req_valid = 1'b1; i_req_addr = 20'h00400;
    tick();
    i_req_valid = 1'b0; i_mem_id_request = 2'd1;
    tick();
    settle();
    chk("t5_in_wait", o_req_ready, 0);
    rst = 1'b0;
    settle();
    chk("t5_rst_ready", o_req_ready, 1);
    tick();
    rst = 1'b1;
    tick();
    i_mem_enable = 1'b1; i_mem_id_response = 2'd1; i_mem_data = D1;
    settle();
    chk("t5_late_ack", o_mem_ack, 0);
    chk("t5_ready", o_req_ready, 1);
    tick();
    chk("t5_no_vld", o_rsp_valid, 0);
    chk("t5_ready2", o_req_ready, 1);
    i_mem_enable = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
